// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Free-running VGA raster timing generator (640x480@60 default)
//                with zero-skew syncs, frame strobe and delayed sync copies.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] C_H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] C_V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] C_HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] C_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] C_VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] C_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       disp_q, disp_d;
  logic       fstart_q, fstart_d;

  // Syncs are decoded from the next counter values so they land on the same
  // edge as the counters they describe.
  always_comb begin
    hc_d     = hc_q + 10'd1;
    vc_d     = vc_q;
    fstart_d = 1'b0;
    if (hc_q == C_H_LAST) begin
      hc_d = '0;
      if (vc_q == C_V_LAST) begin
        vc_d     = '0;
        fstart_d = 1'b1;
      end else begin
        vc_d = vc_q + 10'd1;
      end
    end
    hsync_d = !((hc_d >= C_HS_START) && (hc_d < C_HS_END));
    vsync_d = !((vc_d >= C_VS_START) && (vc_d < C_VS_END));
    disp_d  = (hc_d < C_H_ACT) && (vc_d < C_V_ACT);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q     <= '0;
      vc_q     <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      disp_q   <= 1'b1;
      fstart_q <= 1'b0;
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      disp_q   <= disp_d;
      fstart_q <= fstart_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign blank       = disp_q;
  assign frame_start = fstart_q;

  generate
    if (SYNC_DELAY == 0) begin : g_nodelay
      assign hs_d    = hsync_q;
      assign vs_d    = vsync_q;
      assign blank_d = disp_q;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe_q;
      logic [SYNC_DELAY-1:0] vs_pipe_q;
      logic [SYNC_DELAY-1:0] bl_pipe_q;

      // Reset fills every stage with the inactive level so the delayed copies
      // never show a false visible pixel while the pipe refills.
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          hs_pipe_q <= '1;
          vs_pipe_q <= '1;
          bl_pipe_q <= '0;
        end else begin
          hs_pipe_q[0] <= hsync_q;
          vs_pipe_q[0] <= vsync_q;
          bl_pipe_q[0] <= disp_q;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe_q[i] <= hs_pipe_q[i-1];
            vs_pipe_q[i] <= vs_pipe_q[i-1];
            bl_pipe_q[i] <= bl_pipe_q[i-1];
          end
        end
      end

      assign hs_d    = hs_pipe_q[SYNC_DELAY-1];
      assign vs_d    = vs_pipe_q[SYNC_DELAY-1];
      assign blank_d = bl_pipe_q[SYNC_DELAY-1];
    end
  endgenerate

endmodule
`default_nettype wire
